// File: rtl/nine_segment_pkg.sv
// Shared types and constants for the nine-segment frame sequencer.
package nine_segment_pkg;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_PLAY, SEQ_DONE} seq_state_t;

    localparam int         SEG_W     = 9;
    localparam logic [8:0] SEG_BLANK = '0;

endpackage

// File: rtl/nine_segment_frame_sequencer_frame_ticker.sv
// Frame period counter: counts display cycles and flags the last cycle of each frame.
module frame_ticker
    import nine_segment_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                frame_end_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    // period_i is never 0 here: the top level latches 0 as 1.
    assign frame_end_o = en_i && (cnt_q == period_i - PERIOD_W'(1));

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = frame_end_o ? '0 : cnt_q + PERIOD_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nine_segment_frame_sequencer.sv
// Frame buffer plus playback FSM feeding the 3x3 segment driver; one-shot or looping.
module nine_segment_frame_sequencer
    import nine_segment_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int PERIOD_W = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [SEG_W-1:0]    wr_data_i,
    input  logic [AW-1:0]       last_idx_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                loop_i,
    input  logic                start_i,
    input  logic                stop_i,
    output logic [SEG_W-1:0]    segments_o,
    output logic                busy_o,
    output logic                wrap_o
);

    seq_state_t          state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d, last_q, last_d, idx_inc;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                wrap_q, wrap_d;
    logic [SEG_W-1:0]    mem_q [DEPTH];
    logic                playing, frame_end, boundary, at_last, wr_fire;

    assign playing  = (state_q == SEQ_PLAY);
    assign boundary = frame_end && !stop_i && !start_i;
    assign at_last  = (idx_q == last_q);
    assign idx_inc  = idx_q + AW'(1);
    assign wr_fire  = wr_valid_i && wr_ready_o;

    frame_ticker #(.PERIOD_W(PERIOD_W)) u_ticker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (stop_i || start_i),
        .en_i       (playing),
        .period_i   (period_q),
        .frame_end_o(frame_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stop outranks start, which outranks a frame boundary.
    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = SEQ_IDLE;
        end else if (start_i) begin
            state_d = SEQ_PLAY;
        end else if (boundary && at_last && !loop_i) begin
            state_d = SEQ_DONE;
        end
    end

    always_comb begin
        busy_o     = playing;
        wr_ready_o = !playing;
    end

    always_comb begin
        idx_d    = idx_q;
        seg_d    = seg_q;
        wrap_d   = 1'b0;
        period_d = period_q;
        last_d   = last_q;
        if (stop_i) begin
            idx_d = '0;
            seg_d = SEG_BLANK;
        end else if (start_i) begin
            idx_d    = '0;
            seg_d    = mem_q[0];
            period_d = (period_i == '0) ? PERIOD_W'(1) : period_i;
            last_d   = last_idx_i;
        end else if (boundary) begin
            if (!at_last) begin
                idx_d = idx_inc;
                seg_d = mem_q[idx_inc];
            end else begin
                wrap_d = 1'b1;
                if (loop_i) begin
                    idx_d = '0;
                    seg_d = mem_q[0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            seg_q    <= SEG_BLANK;
            wrap_q   <= 1'b0;
            period_q <= PERIOD_W'(1);
            last_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            wrap_q   <= wrap_d;
            period_q <= period_d;
            last_q   <= last_d;
        end
    end

    // A start in the same cycle as a write reads the pre-write slot 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the frame RAM is a register array that must read back 0 after reset, so it is cleared here.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= SEG_BLANK;
            end
        end else if (wr_fire) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign segments_o = seg_q;
    assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_nine_segment_frame_sequencer.sv
// Directed and randomized checks of the frame sequencer against a cycle-level reference model.
module tb_nine_segment_frame_sequencer;

    localparam int DEPTH    = 8;
    localparam int PERIOD_W = 16;
    localparam int AW       = 3;

    logic                clk;
    logic                rst_n;
    logic                wr_valid_i;
    logic                wr_ready_o;
    logic [AW-1:0]       wr_addr_i;
    logic [8:0]          wr_data_i;
    logic [AW-1:0]       last_idx_i;
    logic [PERIOD_W-1:0] period_i;
    logic                loop_i;
    logic                start_i;
    logic                stop_i;
    logic [8:0]          segments_o;
    logic                busy_o;
    logic                wrap_o;

    nine_segment_frame_sequencer #(.DEPTH(DEPTH), .PERIOD_W(PERIOD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid_i(wr_valid_i),
        .wr_ready_o(wr_ready_o),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .last_idx_i(last_idx_i),
        .period_i  (period_i),
        .loop_i    (loop_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .segments_o(segments_o),
        .busy_o    (busy_o),
        .wrap_o    (wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
        end
    endtask

    // Reference model: frames counted down from the display length, playback as flags.
    int       m_mem [DEPTH];
    bit       m_playing;
    int       m_frame, m_left, m_len, m_last;
    int       m_seg;
    bit       m_wrap;

    function automatic void model_step();
        bit accept;
        if (!rst_n) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_playing = 0; m_frame = 0; m_left = 0; m_len = 1; m_last = 0;
            m_seg = 0; m_wrap = 0;
            return;
        end
        accept = wr_valid_i && !m_playing;
        m_wrap = 0;
        if (stop_i) begin
            m_playing = 0;
            m_frame   = 0;
            m_seg     = 0;
        end else if (start_i) begin
            m_playing = 1;
            m_len     = (period_i == 0) ? 1 : int'(period_i);
            m_last    = int'(last_idx_i);
            m_frame   = 0;
            m_left    = m_len;
            m_seg     = m_mem[0];
        end else if (m_playing) begin
            m_left--;
            if (m_left == 0) begin
                m_left = m_len;
                if (m_frame != m_last) begin
                    m_frame++;
                    m_seg = m_mem[m_frame];
                end else begin
                    m_wrap = 1;
                    if (loop_i) begin
                        m_frame = 0;
                        m_seg   = m_mem[0];
                    end else begin
                        m_playing = 0;
                    end
                end
            end
        end
        if (accept) m_mem[wr_addr_i] = int'(wr_data_i);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("segments", 32'(segments_o), 32'(m_seg));
        check("busy", 32'(busy_o), 32'(m_playing));
        check("wrap", 32'(wrap_o), 32'(m_wrap));
        check("wr_ready", 32'(wr_ready_o), 32'(!m_playing));
    endtask

    task automatic write_slot(input int addr, input int data);
        wr_valid_i = 1'b1;
        wr_addr_i  = AW'(addr);
        wr_data_i  = 9'(data);
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    int wraps;

    initial begin
        rst_n      = 1'b0;
        wr_valid_i = 1'b1;
        wr_addr_i  = 3'd5;
        wr_data_i  = 9'h1A5;
        last_idx_i = '0;
        period_i   = '0;
        loop_i     = 1'b0;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_seg_const", 32'(segments_o), 32'h0);
        wr_valid_i = 1'b0;

        // One-shot: three frames of three cycles each.
        write_slot(0, 9'h1FF);
        write_slot(1, 9'h0AA);
        write_slot(2, 9'h155);
        last_idx_i = 3'd2;
        period_i   = 16'd3;
        loop_i     = 1'b0;
        pulse_start();
        wraps = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (wrap_o) wraps++;
        end
        check("oneshot_wraps", 32'(wraps), 32'd1);
        check("oneshot_hold", 32'(segments_o), 32'h155);
        check("oneshot_busy", 32'(busy_o), 32'd0);

        // Looping with period 0: alternate every cycle, wrap every other cycle.
        loop_i     = 1'b1;
        last_idx_i = 3'd1;
        period_i   = 16'd0;
        write_slot(0, 9'h010);
        write_slot(1, 9'h101);
        pulse_start();
        for (int i = 0; i < 10; i++) tick();

        // Writes blocked during play; restart in the middle of frame 2.
        last_idx_i = 3'd3;
        period_i   = 16'd4;
        write_slot(2, 9'h0F0);
        write_slot(3, 9'h00F);
        pulse_start();
        for (int i = 0; i < 3; i++) write_slot(i, 9'h1C3);
        period_i   = 16'd1;
        last_idx_i = 3'd0;
        for (int i = 0; i < 6; i++) tick();
        pulse_start();
        for (int i = 0; i < 6; i++) tick();

        // stop and start together during play: stop wins.
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("stop_wins_seg", 32'(segments_o), 32'h0);
        tick();
        pulse_start();
        for (int i = 0; i < 5; i++) tick();

        // Reset mid-play clears all slots.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        check("post_reset_seg", 32'(segments_o), 32'h0);
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            stop_i     = ($urandom_range(0, 39) == 0);
            start_i    = ($urandom_range(0, 24) == 0);
            wr_valid_i = ($urandom_range(0, 2) == 0);
            wr_addr_i  = AW'($urandom_range(0, DEPTH - 1));
            wr_data_i  = 9'($urandom);
            last_idx_i = AW'($urandom_range(0, DEPTH - 1));
            period_i   = ($urandom_range(0, 9) == 0) ? PERIOD_W'($urandom_range(5, 12))
                                                     : PERIOD_W'($urandom_range(0, 4));
            loop_i     = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
